// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package hazard_fwd_unit_pkg;

  // EX-stage operand mux selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Scoreboard counter width: must hold values 0..lat
  function automatic int sb_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand bypass select: EX/MEM beats MEM/WB, r0 is never bypassed.
module hazard_fwd_sel
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_wb_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_wb_i,
  output logic [1:0]        sel_o
);

  logic exmem_hit, memwb_hit;

  assign exmem_hit = exmem_wb_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
  assign memwb_hit = memwb_wb_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

  // Priority: the younger producer (EX/MEM) holds the newest value
  always_comb begin
    sel_o = FWD_RF;
    if (exmem_hit)      sel_o = FWD_EXMEM;
    else if (memwb_hit) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding selects, load-use / multi-cycle hazard stall, scoreboard and
// stall performance counter for the ID/EX boundary.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 4,
  parameter int PERF_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NSRC*REG_AW-1:0]   idex_src_i,
  input  logic [NSRC*REG_AW-1:0]   ifid_src_i,
  input  logic                     idex_memread_i,
  input  logic [REG_AW-1:0]        idex_rd_i,
  input  logic [REG_AW-1:0]        exmem_rd_i,
  input  logic                     exmem_wb_i,
  input  logic [REG_AW-1:0]        memwb_rd_i,
  input  logic                     memwb_wb_i,
  input  logic                     mul_issue_i,
  input  logic [REG_AW-1:0]        mul_rd_i,
  output logic [NSRC*2-1:0]        fwd_sel_o,
  output logic                     stall_o,
  output logic                     busy_o,
  output logic [PERF_W-1:0]        stall_cnt_o
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = sb_cnt_w(MUL_LAT);

  logic [NREG-1:0][CW-1:0] sb_q, sb_d;
  logic [PERF_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                    ld_use, raw, waw, mul_accept;

  // Per-operand bypass compare; each operand sees only its own source
  for (genvar k = 0; k < NSRC; k++) begin : g_fwd
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .src_i      (idex_src_i[k*REG_AW +: REG_AW]),
      .exmem_rd_i (exmem_rd_i),
      .exmem_wb_i (exmem_wb_i),
      .memwb_rd_i (memwb_rd_i),
      .memwb_wb_i (memwb_wb_i),
      .sel_o      (fwd_sel_o[k*2 +: 2])
    );
  end

  // Hazard detection against the ID-stage sources (independent of fwd_sel_o)
  always_comb begin
    ld_use = 1'b0;
    raw    = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (idex_memread_i && (idex_rd_i != '0) &&
          (idex_rd_i == ifid_src_i[k*REG_AW +: REG_AW]))
        ld_use = 1'b1;
      if (sb_q[ifid_src_i[k*REG_AW +: REG_AW]] != '0)
        raw = 1'b1;
    end
    waw = mul_issue_i && (sb_q[mul_rd_i] != '0);
  end

  assign stall_o    = ld_use | raw | waw;
  assign mul_accept = mul_issue_i && !stall_o && (mul_rd_i != '0);
  assign busy_o     = |sb_q;

  // Scoreboard next state: load on accepted issue, otherwise count down to 0
  always_comb begin
    sb_d = '0;
    for (int r = 1; r < NREG; r++) begin
      if (mul_accept && (mul_rd_i == REG_AW'(r)))
        sb_d[r] = CW'(MUL_LAT);
      else if (sb_q[r] != '0)
        sb_d[r] = sb_q[r] - CW'(1);
      else
        sb_d[r] = sb_q[r];
    end
  end

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit (REG_AW=5, NSRC=2, MUL_LAT=4).
module tb_hazard_fwd_unit;

  localparam int REG_AW  = 5;
  localparam int NSRC    = 2;
  localparam int MUL_LAT = 4;
  localparam int PERF_W  = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NSRC*REG_AW-1:0] idex_src_i, ifid_src_i;
  logic                   idex_memread_i;
  logic [REG_AW-1:0]      idex_rd_i, exmem_rd_i, memwb_rd_i, mul_rd_i;
  logic                   exmem_wb_i, memwb_wb_i, mul_issue_i;
  logic [NSRC*2-1:0]      fwd_sel_o;
  logic                   stall_o, busy_o;
  logic [PERF_W-1:0]      stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  hazard_fwd_unit #(
    .REG_AW(REG_AW), .NSRC(NSRC), .MUL_LAT(MUL_LAT), .PERF_W(PERF_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .idex_src_i     (idex_src_i),
    .ifid_src_i     (ifid_src_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .exmem_rd_i     (exmem_rd_i),
    .exmem_wb_i     (exmem_wb_i),
    .memwb_rd_i     (memwb_rd_i),
    .memwb_wb_i     (memwb_wb_i),
    .mul_issue_i    (mul_issue_i),
    .mul_rd_i       (mul_rd_i),
    .fwd_sel_o      (fwd_sel_o),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    idex_src_i = '0; ifid_src_i = '0;
    idex_memread_i = 1'b0; idex_rd_i = '0;
    exmem_rd_i = '0; exmem_wb_i = 1'b0;
    memwb_rd_i = '0; memwb_wb_i = 1'b0;
    mul_issue_i = 1'b0; mul_rd_i = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
    chk("rst_fwd", 64'(fwd_sel_o), 64'h0);
    rst_i = 1'b1;

    // Forwarding priority and r0 suppression
    exmem_rd_i = 5'd5; exmem_wb_i = 1'b1; memwb_rd_i = 5'd5; memwb_wb_i = 1'b1;
    idex_src_i = {5'd5, 5'd5}; #1;
    chk("fwd_exmem_both", 64'(fwd_sel_o), 64'b1010);
    exmem_wb_i = 1'b0; #1;
    chk("fwd_memwb_both", 64'(fwd_sel_o), 64'b0101);
    exmem_wb_i = 1'b1; exmem_rd_i = '0; memwb_rd_i = '0;
    idex_src_i = {5'd0, 5'd0}; #1;
    chk("fwd_r0", 64'(fwd_sel_o), 64'b0000);
    exmem_rd_i = 5'd7; exmem_wb_i = 1'b0; memwb_rd_i = 5'd7; memwb_wb_i = 1'b1;
    idex_src_i = {5'd7, 5'd2}; #1;
    chk("fwd_op1_only", 64'(fwd_sel_o), 64'b0100);
    exmem_rd_i = 5'd3; exmem_wb_i = 1'b1; memwb_rd_i = 5'd4;
    idex_src_i = {5'd4, 5'd3}; #1;
    chk("fwd_split", 64'(fwd_sel_o), 64'b0110);
    chk("fwd_no_stall", 64'(stall_o), 64'd0);
    exmem_wb_i = 1'b0; memwb_wb_i = 1'b0;

    // Load-use: one-cycle stall
    idex_memread_i = 1'b1; idex_rd_i = 5'd3; ifid_src_i = {5'd3, 5'd9}; #1;
    chk("ldu_stall", 64'(stall_o), 64'd1);
    chk("ldu_cnt0", 64'(stall_cnt_o), 64'd0);
    tick();
    chk("ldu_cnt1", 64'(stall_cnt_o), 64'd1);
    idex_memread_i = 1'b0; #1;
    chk("ldu_bubble", 64'(stall_o), 64'd0);
    idex_memread_i = 1'b1; idex_rd_i = 5'd0; ifid_src_i = {5'd0, 5'd0}; #1;
    chk("ldu_r0", 64'(stall_o), 64'd0);
    idex_memread_i = 1'b0; ifid_src_i = {5'd1, 5'd2};
    tick();
    chk("ldu_cnt_hold", 64'(stall_cnt_o), 64'd1);

    // RAW on multi-cycle result: stall exactly MUL_LAT cycles
    mul_issue_i = 1'b1; mul_rd_i = 5'd8; #1;
    chk("mul_issue_nostall", 64'(stall_o), 64'd0);
    tick();
    mul_issue_i = 1'b0; ifid_src_i = {5'd8, 5'd2}; #1;
    chk("mul_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < MUL_LAT; i++) begin
      chk($sformatf("raw_stall%0d", i), 64'(stall_o), 64'd1);
      tick();
    end
    chk("raw_release", 64'(stall_o), 64'd0);
    chk("raw_busy_fall", 64'(busy_o), 64'd0);
    chk("raw_cnt", 64'(stall_cnt_o), 64'd5);

    // WAW: second mul to the same register waits for the first
    ifid_src_i = {5'd1, 5'd2}; mul_issue_i = 1'b1; mul_rd_i = 5'd8; #1;
    tick();
    for (int i = 0; i < MUL_LAT; i++) begin
      chk($sformatf("waw_stall%0d", i), 64'(stall_o), 64'd1);
      tick();
    end
    chk("waw_release", 64'(stall_o), 64'd0);
    tick();
    mul_issue_i = 1'b0; #1;
    chk("waw_reissued", 64'(busy_o), 64'd1);
    chk("waw_cnt", 64'(stall_cnt_o), 64'd9);
    repeat (MUL_LAT) tick();
    chk("waw_drained", 64'(busy_o), 64'd0);

    // Mul to r0 never enters the scoreboard
    mul_issue_i = 1'b1; mul_rd_i = 5'd0;
    tick();
    chk("mul_r0_busy", 64'(busy_o), 64'd0);
    chk("mul_r0_stall", 64'(stall_o), 64'd0);
    mul_issue_i = 1'b0;

    // Reset while a counter sits at 2
    mul_issue_i = 1'b1; mul_rd_i = 5'd8;
    tick();
    mul_issue_i = 1'b0;
    tick(); tick();
    ifid_src_i = {5'd8, 5'd2}; #1;
    chk("midrst_pre_stall", 64'(stall_o), 64'd1);
    rst_i = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_cnt", 64'(stall_cnt_o), 64'd0);
    rst_i = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
